disk_xfer_seq: RTL and testbench
================================

Name: disk_xfer_seq

Overview:
- Transfer sequencer for the disk controllers (RK first, later RL/RP).
- A register block starts it with a direction, a 22-bit bus address and a two's-complement word count.
- It splits the transfer into 256-word sectors, handshakes each sector with the microcontroller side (which fills or drains a sector buffer), and moves words between that buffer and QBUS memory through a bus-master request/ack port.
- It reports completion, non-existent-memory errors, and live BA/WC values for register readback.

Parameters:
- ADDR_BITS, 22, width of bus address.
- SECTOR_WORDS, 256, words per sector; must be a power of two.
- BUF_AW, 8, buffer address width, log2(SECTOR_WORDS).

Ports:
- qclk  in  1  controller clock, 20MHz.
- init  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begin transfer.
- wr_disk  in  1  1 = memory->disk (WRITE), 0 = disk->memory (READ); sampled at start.
- ba_in  in  ADDR_BITS  starting byte address, bit 0 ignored.
- wc_in  in  16  negative word count; 0 means 65536 words.
- inh_ba  in  1  inhibit address increment.
- abort  in  1  stop the transfer.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer.
- nxm_err  out  1  sticky until next start.
- ba_out  out  ADDR_BITS  current address.
- wc_out  out  16  current word count.
- sector_req  out  1  level; asks the uC side to write or read one sector.
- sector_ack  in  1  one-cycle pulse; sector finished on uC side.
- buf_addr  out  BUF_AW  sector buffer address.
- buf_we  out  1  buffer write enable.
- buf_wdata  out  16  buffer write data.
- buf_rdata  in  16  buffer read data, one cycle after buf_addr.
- dma_req  out  1  level; request one bus cycle.
- dma_write  out  1  1 = DATO, 0 = DATI.
- dma_addr  out  ADDR_BITS  bus address.
- dma_wdata  out  16  write data.
- dma_rdata  in  16  read data, valid with dma_ack.
- dma_ack  in  1  one-cycle pulse; cycle completed.
- dma_nxm  in  1  one-cycle pulse; cycle timed out. Mutually exclusive with dma_ack.

Behaviour:
- Reset (init, asynchronous): state IDLE; all outputs 0; ba_out=0; wc_out=0.
- States: IDLE, SREQ, BUFRD, DMA, PAD, FIN.
- IDLE, start=1:
  - Latch ba_in (bit0 forced 0), wc_in and wr_disk.
  - Clear nxm_err; busy=1; word index widx=0.
  - Next state: DMA if wr_disk, else SREQ.
  - start while busy is ignored.
- SREQ:
  - sector_req=1 until sector_ack; drop it on the ack cycle.
  - After ack, if wr_disk: wc==0 -> FIN, else widx=0 -> DMA.
  - After ack, if read: widx=0 -> BUFRD.
- BUFRD (read only): buf_addr=widx; one cycle later buf_rdata is loaded into dma_wdata -> DMA.
- DMA:
  - dma_req held with stable dma_addr=ba, dma_write=~wr_disk, until dma_ack or dma_nxm.
  - On dma_ack:
    - If wr_disk, write buf[widx]=dma_rdata (buf_we one cycle).
    - wc<=wc+1; ba<=ba+2 unless inh_ba (wraps modulo 2^ADDR_BITS); widx<=widx+1.
    - Then, evaluated on post-update values:
      - Write direction: widx wrapped to 0 -> SREQ; wc==0 -> PAD; else DMA.
      - Read direction: wc==0 -> FIN; widx wrapped -> SREQ; else BUFRD.
  - On dma_nxm: nxm_err=1; ba/wc not advanced (ba_out = failing address) -> FIN.
- PAD (write only): write 0 to buf[widx..SECTOR_WORDS-1], one word per cycle, then SREQ.
  - A partial final sector is zero-filled on disk.
  - On read, unused words of the last sector are simply not transferred.
- FIN: done=1 for one cycle; busy=0; sector_req=0 -> IDLE.
- abort:
  - From SREQ, BUFRD or PAD: go to FIN next cycle.
  - In DMA: wait for dma_ack or dma_nxm, then FIN. On ack the word counts; a buffered read word is not written on abort.
  - Ignored in IDLE.
- Simultaneity:
  - dma_ack and abort in the same cycle: count the word, then FIN.
  - sector_ack outside SREQ is ignored.
- wc_in=0: 65536 words (256 sectors); terminates when wc returns to 0 after at least one word.
- ba_out and wc_out always show the live registers.
- dma_addr is driven only while dma_req=1, else 0.

Decomposition:
- Add `SECTOR_WORDS and the state encodings (`XS_IDLE .. `XS_FIN) to qsic.vh so later disk controllers share them.
- Flat module; no sub-module. The buffer RAM is external and shared with disk_uc.

Test Plan:
- Read, wc_in=16'hFF00 (256 words), ba_in=22'o1000 -> one sector_req; after ack, 256 DATI-free DATO cycles at 1000, 1002, ..., 1776 carrying buf[0..255]; done pulse; wc_out=0; ba_out=22'o2000.
- Write, wc_in=-300 -> 300 DATI cycles; first sector_req after word 256; words 44..255 of the second sector written as 0; two sector_reqs total; done.
- inh_ba=1, read 10 words at 22'o17777776 -> every dma_addr = 17777776; ba_out unchanged.
- Inject dma_nxm on word 5 of a write -> nxm_err=1; ba_out = ba_in+10; wc_out = wc_in+5; done, with no sector_req.
- abort asserted while dma_req is pending -> req held until ack; then done the next cycle.
- abort asserted during SREQ -> done next cycle.
- Assert init mid-DMA -> all outputs 0 immediately.
- start then reaches IDLE behaviour normally.

Source files
------------

// File: rtl/disk_xfer_seq_pkg.sv
// rtl/disk_xfer_seq_pkg.sv - shared sector size and sequencer state encoding for disk controllers
package disk_xfer_seq_pkg;

  // Words per disk sector and matching buffer address width.
  localparam int XS_SECTOR_WORDS = 256;
  localparam int XS_BUF_AW       = 8;

  // Transfer sequencer states, shared so RK/RL/RP controllers decode them alike.
  typedef enum logic [2:0] {
    XS_IDLE  = 3'd0,
    XS_SREQ  = 3'd1,
    XS_BUFRD = 3'd2,
    XS_DMA   = 3'd3,
    XS_PAD   = 3'd4,
    XS_FIN   = 3'd5
  } xs_state_e;

endpackage

// File: rtl/disk_xfer_seq.sv
// rtl/disk_xfer_seq.sv - sector-by-sector transfer sequencer between sector buffer and QBUS memory
module disk_xfer_seq
  import disk_xfer_seq_pkg::*;
#(
  parameter int ADDR_BITS    = 22,
  parameter int SECTOR_WORDS = XS_SECTOR_WORDS,
  parameter int BUF_AW       = XS_BUF_AW
) (
  input  logic                 qclk,
  input  logic                 init,
  input  logic                 start,
  input  logic                 wr_disk,
  input  logic [ADDR_BITS-1:0] ba_in,
  input  logic [15:0]          wc_in,
  input  logic                 inh_ba,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 nxm_err,
  output logic [ADDR_BITS-1:0] ba_out,
  output logic [15:0]          wc_out,
  output logic                 sector_req,
  input  logic                 sector_ack,
  output logic [BUF_AW-1:0]    buf_addr,
  output logic                 buf_we,
  output logic [15:0]          buf_wdata,
  input  logic [15:0]          buf_rdata,
  output logic                 dma_req,
  output logic                 dma_write,
  output logic [ADDR_BITS-1:0] dma_addr,
  output logic [15:0]          dma_wdata,
  input  logic [15:0]          dma_rdata,
  input  logic                 dma_ack,
  input  logic                 dma_nxm
);

  xs_state_e            state_q, state_d;
  logic [ADDR_BITS-1:0] ba_q, ba_d;
  logic [15:0]          wc_q, wc_d;
  logic [BUF_AW-1:0]    widx_q, widx_d;
  logic                 wr_q, wr_d;
  logic                 nxm_q, nxm_d;
  logic                 rdph_q, rdph_d;   // BUFRD: 0 = address presented, 1 = data available
  logic [15:0]          wdata_q, wdata_d;

  logic [ADDR_BITS-1:0] ba_step;
  logic [15:0]          wc_inc;
  logic [BUF_AW-1:0]    widx_inc;

  assign ba_step  = inh_ba ? ba_q : ba_q + ADDR_BITS'(2);
  assign wc_inc   = wc_q + 16'd1;
  assign widx_inc = widx_q + BUF_AW'(1);

  assign ba_out    = ba_q;
  assign wc_out    = wc_q;
  assign nxm_err   = nxm_q;
  assign dma_wdata = wdata_q;

  // State and datapath registers; init clears everything at once.
  always_ff @(posedge qclk or posedge init) begin
    if (init) begin
      state_q <= XS_IDLE;
      ba_q    <= '0;
      wc_q    <= '0;
      widx_q  <= '0;
      wr_q    <= 1'b0;
      nxm_q   <= 1'b0;
      rdph_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ba_q    <= ba_d;
      wc_q    <= wc_d;
      widx_q  <= widx_d;
      wr_q    <= wr_d;
      nxm_q   <= nxm_d;
      rdph_q  <= rdph_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and output decode; address/count advance only on a completed bus cycle.
  always_comb begin
    state_d    = state_q;
    ba_d       = ba_q;
    wc_d       = wc_q;
    widx_d     = widx_q;
    wr_d       = wr_q;
    nxm_d      = nxm_q;
    rdph_d     = rdph_q;
    wdata_d    = wdata_q;
    busy       = 1'b0;
    done       = 1'b0;
    sector_req = 1'b0;
    buf_addr   = '0;
    buf_we     = 1'b0;
    buf_wdata  = '0;
    dma_req    = 1'b0;
    dma_write  = 1'b0;
    dma_addr   = '0;

    case (state_q)
      XS_IDLE: begin
        if (start) begin
          ba_d    = ba_in & ~ADDR_BITS'(1);
          wc_d    = wc_in;
          wr_d    = wr_disk;
          nxm_d   = 1'b0;
          widx_d  = '0;
          rdph_d  = 1'b0;
          state_d = wr_disk ? XS_DMA : XS_SREQ;
        end
      end

      XS_SREQ: begin
        busy       = 1'b1;
        sector_req = ~sector_ack;
        if (abort) begin
          state_d = XS_FIN;
        end else if (sector_ack) begin
          widx_d = '0;
          rdph_d = 1'b0;
          if (wr_q) begin
            state_d = (wc_q == 16'd0) ? XS_FIN : XS_DMA;
          end else begin
            state_d = XS_BUFRD;
          end
        end
      end

      XS_BUFRD: begin
        busy     = 1'b1;
        buf_addr = widx_q;
        if (abort) begin
          state_d = XS_FIN;
        end else if (!rdph_q) begin
          rdph_d = 1'b1;
        end else begin
          wdata_d = buf_rdata;
          rdph_d  = 1'b0;
          state_d = XS_DMA;
        end
      end

      XS_DMA: begin
        busy      = 1'b1;
        dma_req   = 1'b1;
        dma_write = ~wr_q;
        dma_addr  = ba_q;
        buf_addr  = widx_q;
        if (dma_nxm) begin
          nxm_d   = 1'b1;
          state_d = XS_FIN;
        end else if (dma_ack) begin
          buf_we    = wr_q;
          buf_wdata = dma_rdata;
          wc_d      = wc_inc;
          ba_d      = ba_step;
          widx_d    = widx_inc;
          if (abort) begin
            state_d = XS_FIN;
          end else if (wr_q) begin
            if (widx_inc == '0)        state_d = XS_SREQ;
            else if (wc_inc == 16'd0)  state_d = XS_PAD;
            else                       state_d = XS_DMA;
          end else begin
            if (wc_inc == 16'd0)       state_d = XS_FIN;
            else if (widx_inc == '0)   state_d = XS_SREQ;
            else                       state_d = XS_BUFRD;
          end
        end
      end

      XS_PAD: begin
        busy = 1'b1;
        if (abort) begin
          state_d = XS_FIN;
        end else begin
          buf_addr = widx_q;
          buf_we   = 1'b1;
          widx_d   = widx_inc;
          if (widx_q == BUF_AW'(SECTOR_WORDS - 1)) state_d = XS_SREQ;
        end
      end

      XS_FIN: begin
        done    = 1'b1;
        state_d = XS_IDLE;
      end

      default: state_d = XS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_disk_xfer_seq.sv
// tb/tb_disk_xfer_seq.sv - scoreboard bench for disk_xfer_seq with bus and uC responders
module tb_disk_xfer_seq;

  logic        qclk = 1'b0;
  logic        init, start, wr_disk, inh_ba, abort, sector_ack, dma_ack, dma_nxm;
  logic [21:0] ba_in;
  logic [15:0] wc_in, buf_rdata, dma_rdata;
  logic        busy, done, nxm_err, sector_req, buf_we, dma_req, dma_write;
  logic [21:0] ba_out, dma_addr;
  logic [15:0] wc_out, buf_wdata, dma_wdata;
  logic [7:0]  buf_addr;

  disk_xfer_seq dut (
    .qclk(qclk), .init(init), .start(start), .wr_disk(wr_disk), .ba_in(ba_in),
    .wc_in(wc_in), .inh_ba(inh_ba), .abort(abort), .busy(busy), .done(done),
    .nxm_err(nxm_err), .ba_out(ba_out), .wc_out(wc_out), .sector_req(sector_req),
    .sector_ack(sector_ack), .buf_addr(buf_addr), .buf_we(buf_we), .buf_wdata(buf_wdata),
    .buf_rdata(buf_rdata), .dma_req(dma_req), .dma_write(dma_write), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack), .dma_nxm(dma_nxm)
  );

  always #25 qclk = ~qclk;

  int cyc = 0;
  always @(posedge qclk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Current transfer description shared with the responders.
  bit          t_wr, t_inh, uc_hold;
  logic [21:0] t_ba0;
  int          t_n, t_nxm_at = -1, t_abort_at = -1;
  logic [15:0] t_seed;
  int          word_cnt, sect_cnt, rd_sector, bus_delay, sdelay, ack_cyc;
  logic [21:0] exp_ba;
  logic [15:0] exp_wc;
  bit          exp_nxm;
  int          exp_sect;

  typedef struct {
    logic [21:0] addr;
    logic        wr;
    logic [15:0] data;
    logic        chk_data;
  } dma_exp_t;
  dma_exp_t dma_q[$];

  logic [15:0] bufm [256];

  function automatic logic [15:0] mem_word(logic [21:0] a);
    return a[15:0] ^ {a[21:16], 10'h2B5};
  endfunction

  function automatic logic [15:0] fill_k(int k);
    return t_seed ^ 16'(k * 7 + 3);
  endfunction

  function automatic logic [21:0] addr_of(int k);
    if (t_inh) return t_ba0;
    return 22'(32'(t_ba0) + 32'(2 * k));
  endfunction

  // Sector buffer: the DUT fills it on writes; on reads the uC side supplies sector data.
  always @(posedge qclk) begin
    if (buf_we) bufm[buf_addr] <= buf_wdata;
    if (t_wr) buf_rdata <= bufm[buf_addr];
    else      buf_rdata <= fill_k(rd_sector * 256 + int'(buf_addr));
  end

  // QBUS slave: random latency, optional nxm on one word, optional abort while pending.
  initial begin
    dma_ack = 0; dma_nxm = 0; dma_rdata = 0; bus_delay = 0; abort = 0;
    forever begin
      @(posedge qclk); #1;
      dma_ack = 0; dma_nxm = 0;
      if (init) begin
        bus_delay = 0;
      end else if (dma_req) begin
        if (t_abort_at >= 0 && word_cnt == t_abort_at && !abort) begin
          abort = 1;
          bus_delay = $urandom_range(0, 2);
        end else if (bus_delay > 0) begin
          bus_delay--;
        end else begin
          if (word_cnt == t_nxm_at) dma_nxm = 1;
          else begin
            dma_ack = 1;
            dma_rdata = mem_word(dma_addr);
          end
          ack_cyc = cyc;
          word_cnt++;
          bus_delay = $urandom_range(0, 2);
        end
      end
    end
  end

  // uC side: acks sector requests; on disk writes checks the buffer image against the model.
  initial begin
    sector_ack = 0; sdelay = 0;
    forever begin
      @(posedge qclk); #1;
      sector_ack = 0;
      if (init) begin
        sdelay = 0;
      end else if (sector_req && !uc_hold) begin
        if (sdelay > 0) begin
          sdelay--;
        end else begin
          if (t_wr) begin
            int bw;
            logic [15:0] ew;
            bw = 255;
            for (int w = 0; w < 256; w++) begin
              int k;
              k = sect_cnt * 256 + w;
              ew = (k < t_n) ? mem_word(addr_of(k)) : 16'h0;
              if (bufm[w] !== ew) begin bw = w; break; end
            end
            begin
              int k2;
              k2 = sect_cnt * 256 + bw;
              chk("sector_data", bufm[bw], (k2 < t_n) ? mem_word(addr_of(k2)) : 16'h0);
            end
          end else begin
            rd_sector = sect_cnt;
          end
          sector_ack = 1;
          sect_cnt++;
          sdelay = $urandom_range(0, 3);
        end
      end
    end
  end

  // Monitor: every completed or failed bus cycle is checked against the expected queue.
  initial begin
    forever begin
      @(negedge qclk);
      if (dma_req && (dma_ack || dma_nxm)) begin
        chk("dma_expected", 32'(dma_q.size() > 0), 1);
        if (dma_q.size() > 0) begin
          dma_exp_t e;
          e = dma_q.pop_front();
          chk("dma_addr", dma_addr, e.addr);
          chk("dma_write", dma_write, e.wr);
          if (e.chk_data) chk("dma_wdata", dma_wdata, e.data);
        end
      end
    end
  end

  task automatic setup_xfer(input bit wr, input logic [21:0] ba, input int n, input bit inh,
                            input int nxm_at, input int abort_at);
    int m_att, words_done;
    logic [15:0] wc0;
    dma_exp_t e;
    t_wr = wr; t_ba0 = ba & 22'h3FFFFE; t_n = n; t_inh = inh;
    t_nxm_at = nxm_at; t_abort_at = abort_at; t_seed = 16'($urandom);
    wc0 = 16'(65536 - n);
    if (nxm_at >= 0)        m_att = nxm_at + 1;
    else if (abort_at >= 0) m_att = abort_at + 1;
    else                    m_att = n;
    words_done = (nxm_at >= 0) ? nxm_at : m_att;
    dma_q.delete();
    for (int k = 0; k < m_att; k++) begin
      e.addr = addr_of(k); e.wr = !wr; e.data = fill_k(k); e.chk_data = !wr;
      dma_q.push_back(e);
    end
    if (wr) exp_sect = (nxm_at >= 0) ? nxm_at / 256 : (abort_at >= 0) ? abort_at / 256 : (n + 255) / 256;
    else    exp_sect = (nxm_at >= 0) ? nxm_at / 256 + 1 : (abort_at >= 0) ? abort_at / 256 + 1 : (n + 255) / 256;
    exp_ba  = addr_of(words_done);
    exp_wc  = wc0 + 16'(words_done);
    exp_nxm = (nxm_at >= 0);
    word_cnt = 0; sect_cnt = 0; rd_sector = 0;
    @(posedge qclk); #1;
    start = 1; wr_disk = wr; ba_in = ba; wc_in = wc0; inh_ba = inh;
    @(posedge qclk); #1;
    start = 0; ba_in = 22'($urandom); wc_in = 16'($urandom); wr_disk = 1'($urandom);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_xfer();
    int budget;
    bit got;
    budget = 20 * t_n + 3000;
    got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge qclk);
      if (done) begin got = 1; break; end
    end
    chk("done_seen", got, 1);
    if (got) begin
      chk("ba_out", ba_out, exp_ba);
      chk("wc_out", wc_out, exp_wc);
      chk("nxm_err", nxm_err, exp_nxm);
      chk("busy_fin", busy, 0);
      if (t_abort_at >= 0) chk("abort_done_latency", cyc, ack_cyc + 1);
      @(negedge qclk);
      chk("done_pulse", done, 0);
      chk("sector_reqs", sect_cnt, exp_sect);
      chk("dma_left", dma_q.size(), 0);
    end else begin
      init = 1; #5; init = 0;
    end
    abort = 0; t_abort_at = -1; t_nxm_at = -1;
    dma_q.delete();
  endtask

  initial begin
    init = 1; start = 0; wr_disk = 0; inh_ba = 0; ba_in = 0; wc_in = 0; uc_hold = 0;
    t_wr = 0; t_inh = 0; t_ba0 = 0; t_n = 0; t_seed = 0;
    word_cnt = 0; sect_cnt = 0; rd_sector = 0; ack_cyc = 0;
    #1;
    chk("reset_ctrl", {busy, done, nxm_err, sector_req, dma_req, dma_write, buf_we}, 0);
    chk("reset_ba", ba_out, 0);
    chk("reset_wc", wc_out, 0);
    chk("reset_dma_addr", dma_addr, 0);
    chk("reset_buf_addr", buf_addr, 0);
    repeat (3) @(posedge qclk);
    #1 init = 0;

    // One full read sector at 1000 (octal).
    setup_xfer(0, 22'o1000, 256, 0, -1, -1); finish_xfer();
    // 300-word write: one full sector, then a padded one.
    setup_xfer(1, 22'o20000, 300, 0, -1, -1); finish_xfer();
    // Address increment inhibited at the top of memory.
    setup_xfer(0, 22'o17777776, 10, 1, -1, -1); finish_xfer();
    // NXM on word 5 of a write.
    setup_xfer(1, 22'o4000, 20, 0, 5, -1); finish_xfer();
    // Address wrap past 2^22, odd start address.
    setup_xfer(1, 22'h3FFFF9, 20, 0, -1, -1); finish_xfer();
    // Abort while bus cycle pending, read and write.
    setup_xfer(0, 22'o6000, 40, 0, -1, 7); finish_xfer();
    setup_xfer(1, 22'o7000, 300, 0, -1, 255); finish_xfer();

    // Abort while waiting for a sector.
    begin
      bit got;
      int c0;
      uc_hold = 1;
      setup_xfer(0, 22'o2000, 16, 0, -1, -1);
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge qclk);
        if (sector_req) begin got = 1; break; end
      end
      chk("sreq_seen", got, 1);
      @(posedge qclk); #1; abort = 1; c0 = cyc;
      @(posedge qclk); @(negedge qclk);
      chk("sreq_abort_done", done, 1);
      chk("sreq_abort_lat", cyc, c0 + 1);
      chk("sreq_abort_req", sector_req, 0);
      @(posedge qclk); #1; abort = 0; uc_hold = 0;
      @(negedge qclk);
      chk("sreq_abort_sects", sect_cnt, 0);
      dma_q.delete();
    end

    // Reset in the middle of a DMA burst, then a normal transfer.
    begin
      bit got;
      setup_xfer(1, 22'o10000, 50, 0, -1, -1);
      got = 0;
      for (int i = 0; i < 400; i++) begin
        @(negedge qclk);
        if (dma_req && word_cnt >= 3) begin got = 1; break; end
      end
      chk("dma_seen_before_init", got, 1);
      #5 init = 1;
      #1;
      chk("init_ctrl", {busy, done, nxm_err, sector_req, dma_req, dma_write, buf_we}, 0);
      chk("init_ba", ba_out, 0);
      chk("init_wc", wc_out, 0);
      chk("init_dma_addr", dma_addr, 0);
      @(posedge qclk); @(negedge qclk);
      init = 0;
      dma_q.delete();
      setup_xfer(0, 22'o30000, 30, 0, -1, -1); finish_xfer();
    end

    // Randomized transfers.
    for (int r = 0; r < 12; r++) begin
      int n, sel, nx, ab;
      n = $urandom_range(1, 400);
      sel = $urandom_range(0, 4);
      nx = (sel == 0) ? int'($urandom_range(0, n - 1)) : -1;
      ab = (sel == 1) ? int'($urandom_range(0, n - 1)) : -1;
      setup_xfer(1'($urandom), 22'($urandom), n, ($urandom_range(0, 3) == 0), nx, ab);
      finish_xfer();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
